// File: rtl/port_rx_buffer_pkg.sv
// Shared definitions for the Port receive path: rx FSM state encoding and
// the line/FIFO defaults shared with the Port transmitter.
package port_rx_buffer_pkg;

    localparam int DEF_DATA_W       = 8;
    localparam int DEF_CLKS_PER_BIT = 16;
    localparam int DEF_DEPTH        = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_e;

endpackage

// File: rtl/port_rx_buffer_fifo.sv
// Circular FIFO with registered read data and registered empty/full flags,
// using the r/dout/is_empty/is_full handshake shared with the transmit side.
module rx_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              is_empty,
    output logic              is_full,
    output logic              accepted
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              is_empty_q, is_empty_d, is_full_q, is_full_d;
    logic              pop_ok, push_ok;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        pop_ok  = pop && !is_empty_q;
        // A read in the same cycle frees a slot, so a push into a full FIFO still lands.
        push_ok = push && (!is_full_q || pop_ok);

        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        dout_d   = pop_ok  ? mem[rd_ptr_q] : dout_q;

        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_W'(1);
        end

        is_empty_d = (count_d == '0);
        is_full_d  = (count_d == FULL_CNT);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            dout_q     <= '0;
            is_empty_q <= 1'b1;
            is_full_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            dout_q     <= dout_d;
            is_empty_q <= is_empty_d;
            is_full_q  <= is_full_d;
        end
    end

    // NOTE: storage is not reset; the pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= din;
        end
    end

    assign dout     = dout_q;
    assign is_empty = is_empty_q;
    assign is_full  = is_full_q;
    assign accepted = push_ok;

endmodule

// File: rtl/port_rx_buffer.sv
// 8N1 serial receiver with mid-bit sampling feeding an rx_fifo that the hub
// drains; sticky frame/overrun error flags.
module port_rx_buffer
    import port_rx_buffer_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int DATA_W       = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    input  logic              r,
    output logic [DATA_W-1:0] dout,
    output logic              is_empty,
    output logic              is_full,
    output logic              rec_complete,
    output logic              frame_err,
    output logic              overrun,
    input  logic              err_clr
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_M1   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    logic              rx_meta_q, rx_s_q;
    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;
    logic              push, stop_bad, fifo_accepted;

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q + CNT_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push      = 1'b0;
        stop_bad  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                clk_cnt_d = '0;
                if (!rx_s_q) begin
                    state_d   = ST_START;
                    bit_idx_d = '0;
                end
            end
            ST_START: begin
                // Re-check mid start bit; a line that is high again was a glitch.
                if (clk_cnt_q == HALF_M1) begin
                    clk_cnt_d = '0;
                    state_d   = rx_s_q ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (clk_cnt_q == BIT_M1) begin
                    clk_cnt_d          = '0;
                    shift_d[bit_idx_q] = rx_s_q;
                    bit_idx_d          = bit_idx_q + IDX_W'(1);
                    if (bit_idx_q == LAST_IDX) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (clk_cnt_q == BIT_M1) begin
                    clk_cnt_d = '0;
                    if (rx_s_q) begin
                        push    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        stop_bad = 1'b1;
                        state_d  = ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                // Hold off until the line returns high so a break cannot retrigger.
                clk_cnt_d = '0;
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Set wins over a simultaneous clear.
    always_comb begin
        frame_err_d = stop_bad | (frame_err_q & ~err_clr);
        overrun_d   = (push & ~fifo_accepted) | (overrun_q & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= ST_IDLE;
            clk_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rx_s_q      <= rx_meta_q;
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    rx_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (r),
        .din      (shift_q),
        .dout     (dout),
        .is_empty (is_empty),
        .is_full  (is_full),
        .accepted (fifo_accepted)
    );

    assign rec_complete = fifo_accepted;
    assign frame_err    = frame_err_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_port_rx_buffer.sv
// Directed bench for port_rx_buffer: a queue-based line/FIFO model checked
// every cycle, plus hand-computed literal expectations.
module tb_port_rx_buffer;

    localparam int CPB   = 16;
    localparam int DEPTH = 8;
    localparam int DW    = 8;
    // Start bit driven in cycle c; the stop bit is judged at its middle,
    // seen 2 cycles late through the synchroniser.
    localparam int PUSH_OFS = 2 + 9 * CPB + CPB / 2;

    logic          clk = 1'b0;
    logic          reset, rx, r, err_clr;
    logic [DW-1:0] dout;
    logic          is_empty, is_full, rec_complete, frame_err, overrun;

    always #5 clk = ~clk;

    port_rx_buffer #(
        .CLKS_PER_BIT (CPB),
        .DEPTH        (DEPTH),
        .DATA_W       (DW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .r            (r),
        .dout         (dout),
        .is_empty     (is_empty),
        .is_full      (is_full),
        .rec_complete (rec_complete),
        .frame_err    (frame_err),
        .overrun      (overrun),
        .err_clr      (err_clr)
    );

    typedef struct {
        int          due;
        logic [7:0]  data;
        bit          good;
    } rx_ev_t;

    rx_ev_t     ev_q[$];
    logic [7:0] m_fifo[$];
    logic [7:0] exp_dout = '0;
    bit         exp_ferr = 1'b0;
    bit         exp_ovr  = 1'b0;
    int         pulse_log[$];
    int         cyc    = 0;
    bit         chk_en = 1'b0;
    int         errors = 0;
    int         checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare the DUT against the model, then advance the model across the next edge.
    always @(negedge clk) begin
        bit         due, good, pop_ok, push_try, push_ok;
        logic [7:0] data;
        if (chk_en) begin
            due  = 1'b0;
            good = 1'b0;
            data = '0;
            if (ev_q.size() > 0) begin
                due = (ev_q[0].due == cyc);
            end
            if (due) begin
                good = ev_q[0].good;
                data = ev_q[0].data;
            end
            pop_ok   = r && (m_fifo.size() > 0);
            push_try = due && good;
            push_ok  = push_try && ((m_fifo.size() < DEPTH) || pop_ok);

            check("m_dout", dout, exp_dout);
            check("m_is_empty", is_empty, m_fifo.size() == 0);
            check("m_is_full", is_full, m_fifo.size() == DEPTH);
            check("m_frame_err", frame_err, exp_ferr);
            check("m_overrun", overrun, exp_ovr);
            check("m_rec_complete", rec_complete, push_ok);
            if (rec_complete === 1'b1) pulse_log.push_back(cyc);

            if (reset) begin
                m_fifo.delete();
                ev_q.delete();
                exp_dout = '0;
                exp_ferr = 1'b0;
                exp_ovr  = 1'b0;
            end else begin
                if (pop_ok) exp_dout = m_fifo.pop_front();
                if (push_ok) m_fifo.push_back(data);
                exp_ferr = (due && !good) ? 1'b1 : (err_clr ? 1'b0 : exp_ferr);
                exp_ovr  = (push_try && !push_ok) ? 1'b1 : (err_clr ? 1'b0 : exp_ovr);
                if (due) void'(ev_q.pop_front());
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_frame(input logic [7:0] data, input bit stop_bad = 1'b0,
                              input bit rd_on_push = 1'b0, input bit rst_mid = 1'b0);
        int         c0;
        logic [9:0] bits;
        c0   = cyc;
        bits = {~stop_bad, data, 1'b0};
        ev_q.push_back('{due: c0 + PUSH_OFS, data: data, good: !stop_bad});
        for (int b = 0; b < 10; b++) begin
            for (int j = 0; j < CPB; j++) begin
                rx = bits[b];
                if (rd_on_push) r = (cyc == c0 + PUSH_OFS);
                if (rst_mid) reset = (b == 5) && (j == 8 || j == 9);
                tick();
            end
        end
        if (rd_on_push) r = 1'b0;
        if (rst_mid) reset = 1'b0;
        if (stop_bad) begin
            rx = 1'b0;
            repeat (CPB) tick();
        end
        rx = 1'b1;
    endtask

    task automatic read_byte(input logic [7:0] exp, input string name);
        r = 1'b1;
        tick();
        r = 1'b0;
        check(name, dout, exp);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    initial begin
        int n;
        reset   = 1'b1;
        rx      = 1'b1;
        r       = 1'b0;
        err_clr = 1'b0;
        tick();
        chk_en = 1'b1;
        idle(2);
        reset = 1'b0;
        check("rst_dout", dout, 0);
        check("rst_is_empty", is_empty, 1);
        check("rst_is_full", is_full, 0);
        check("rst_rec_complete", rec_complete, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        idle(4);

        // Back-to-back frames with no idle gap
        send_frame(8'h7E);
        send_frame(8'hDC);
        idle(4);
        check("b2b_pulses", pulse_log.size(), 2);
        if (pulse_log.size() >= 2) check("b2b_gap", pulse_log[1] - pulse_log[0], 160);
        read_byte(8'h7E, "b2b_rd0");
        read_byte(8'hDC, "b2b_rd1");
        tick();
        check("b2b_empty", is_empty, 1);

        // Short low glitch on an idle line
        n  = pulse_log.size();
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(40);
        check("glitch_no_pulse", pulse_log.size(), n);
        check("glitch_empty", is_empty, 1);
        check("glitch_ferr", frame_err, 0);
        check("glitch_ovr", overrun, 0);

        // Read request while empty is ignored
        r = 1'b1;
        tick();
        r = 1'b0;
        check("rde_dout_held", dout, 8'hDC);
        check("rde_empty", is_empty, 1);
        send_frame(8'h5A);
        idle(4);
        read_byte(8'h5A, "rde_next_byte");

        // Framing error, recovery, then clear
        send_frame(8'h55, 1'b1);
        idle(8);
        check("ferr_set", frame_err, 1);
        check("ferr_empty", is_empty, 1);
        send_frame(8'hA5);
        idle(4);
        read_byte(8'hA5, "ferr_next_byte");
        check("ferr_still_set", frame_err, 1);
        pulse_clr();
        check("ferr_cleared", frame_err, 0);

        // Overrun: nine frames into an eight-entry FIFO
        for (int i = 1; i <= 8; i++) send_frame(8'(i));
        idle(4);
        check("ovr_full_at_8", is_full, 1);
        check("ovr_not_yet", overrun, 0);
        send_frame(8'h09);
        idle(4);
        check("ovr_set", overrun, 1);
        for (int i = 1; i <= 8; i++) read_byte(8'(i), "ovr_rd");
        tick();
        check("ovr_drained", is_empty, 1);
        pulse_clr();
        check("ovr_cleared", overrun, 0);

        // Same again with a read coinciding with the ninth push
        for (int i = 1; i <= 8; i++) send_frame(8'(i));
        send_frame(8'h09, 1'b0, 1'b1);
        idle(4);
        check("rop_no_ovr", overrun, 0);
        check("rop_full", is_full, 1);
        check("rop_dout", dout, 8'h01);
        for (int i = 2; i <= 9; i++) read_byte(8'(i), "rop_rd");
        tick();
        check("rop_drained", is_empty, 1);

        // Reset in the middle of data bit 4 discards the frame and the FIFO
        send_frame(8'h11);
        idle(4);
        check("rstm_pre_fill", is_empty, 0);
        n = pulse_log.size();
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
        idle(4);
        check("rstm_no_pulse", pulse_log.size(), n);
        check("rstm_dout", dout, 0);
        check("rstm_empty", is_empty, 1);
        check("rstm_full", is_full, 0);
        check("rstm_ferr", frame_err, 0);
        check("rstm_ovr", overrun, 0);
        send_frame(8'h3C);
        idle(4);
        read_byte(8'h3C, "rstm_next_byte");
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        errors++;
        checks++;
        $display("FAIL watchdog: got timeout, expected sequence to complete");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
